// File: rtl/mult_acc_if.sv
// rtl/mult_acc_if.sv - product stream in, frame result out, status for mult_acc
interface mult_acc_if #(
    parameter int ACC_W = 12,
    parameter int CNT_W = 4
);
    logic             clr;
    logic [7:0]       dat_in;
    logic             dat_vld;
    logic [ACC_W-1:0] sum;
    logic             sum_vld;
    logic             sum_rdy;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             drop;

    modport master (
        output clr, dat_in, dat_vld, sum_rdy,
        input  sum, sum_vld, cnt, ovf, drop
    );

    modport slave (
        input  clr, dat_in, dat_vld, sum_rdy,
        output sum, sum_vld, cnt, ovf, drop
    );
endinterface

// File: rtl/mult_acc.sv
// rtl/mult_acc.sv - sums every LEN valid products into a single-entry handshaked result register
module mult_acc #(
    parameter int LEN   = 8,
    parameter int ACC_W = 12,
    parameter int CNT_W = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    mult_acc_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt, fin;
    logic [CNT_W-1:0] cnt_r, cnt_nxt;
    logic             ovf_r, ovf_nxt, fin_vld;
    logic [ACC_W-1:0] sum_r;
    logic             sum_vld_r, drop_r;
    logic [ACC_W:0]   add_w;

    // Extra top bit captures the carry out of the accumulator for ovf.
    assign add_w = {1'b0, acc} + {{(ACC_W-7){1'b0}}, bus.dat_in};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt_r <= '0;
            ovf_r <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt_r <= cnt_nxt;
            ovf_r <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt_r;
        ovf_nxt   = ovf_r;
        fin       = add_w[ACC_W-1:0];
        fin_vld   = 1'b0;
        if (bus.clr) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
        end else if (bus.dat_vld) begin
            case (state)
                IDLE: begin
                    acc_nxt   = {{(ACC_W-8){1'b0}}, bus.dat_in};
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = RUN;
                end
                RUN: begin
                    if (add_w[ACC_W])
                        ovf_nxt = 1'b1;
                    if (cnt_r == CNT_W'(LEN-1)) begin
                        fin_vld   = 1'b1;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        acc_nxt = add_w[ACC_W-1:0];
                        cnt_nxt = cnt_r + CNT_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A completing handshake frees the register in the same cycle a new result lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_r     <= '0;
            sum_vld_r <= 1'b0;
            drop_r    <= 1'b0;
        end else begin
            drop_r <= 1'b0;
            if (fin_vld) begin
                if (!sum_vld_r || bus.sum_rdy) begin
                    sum_r     <= fin;
                    sum_vld_r <= 1'b1;
                end else begin
                    drop_r <= 1'b1;
                end
            end else if (sum_vld_r && bus.sum_rdy) begin
                sum_vld_r <= 1'b0;
            end
        end
    end

    assign bus.sum     = sum_r;
    assign bus.sum_vld = sum_vld_r;
    assign bus.cnt     = cnt_r;
    assign bus.ovf     = ovf_r;
    assign bus.drop    = drop_r;
endmodule

// File: tb/tb_mult_acc.sv
// tb/tb_mult_acc.sv - randomized and directed check of mult_acc at two accumulator widths
module tb_mult_acc;
    localparam int LEN = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_acc_if #(.ACC_W(12), .CNT_W(4)) b12 ();
    mult_acc_if #(.ACC_W(9),  .CNT_W(4)) b9 ();

    mult_acc #(.LEN(LEN), .ACC_W(12), .CNT_W(4)) u_dut12 (.clk(clk), .rst_n(rst_n), .bus(b12));
    mult_acc #(.LEN(LEN), .ACC_W(9),  .CNT_W(4)) u_dut9  (.clk(clk), .rst_n(rst_n), .bus(b9));

    int n_chk = 0;
    int n_fail = 0;

    int frame_q[$];
    int wid[2] = '{12, 9};
    int m_sum[2];
    int m_ovf[2];
    int m_sv;
    int m_drop;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit v, input int d, input bit r, input bit c, input bit rs);
        int part;
        int fin[2];
        bit fin_ok;
        fin_ok = 1'b0;
        fin = '{0, 0};
        if (!rs) begin
            frame_q.delete();
            m_sum = '{0, 0};
            m_ovf = '{0, 0};
            m_sv = 0;
            m_drop = 0;
            return;
        end
        m_drop = 0;
        if (c) begin
            frame_q.delete();
            m_ovf = '{0, 0};
        end else if (v) begin
            frame_q.push_back(d);
            part = 0;
            foreach (frame_q[i]) part += frame_q[i];
            for (int k = 0; k < 2; k++) begin
                if (part >= (1 << wid[k])) m_ovf[k] = 1;
                fin[k] = part % (1 << wid[k]);
            end
            if (frame_q.size() == LEN) begin
                fin_ok = 1'b1;
                frame_q.delete();
            end
        end
        if (fin_ok) begin
            if (m_sv == 0 || r) begin
                m_sum = fin;
                m_sv = 1;
            end else begin
                m_drop = 1;
            end
        end else if (m_sv != 0 && r) begin
            m_sv = 0;
        end
    endtask

    task automatic step(input bit v, input int d, input bit r, input bit c, input bit rs);
        rst_n = rs;
        b12.dat_vld = v; b9.dat_vld = v;
        b12.dat_in = 8'(d); b9.dat_in = 8'(d);
        b12.sum_rdy = r; b9.sum_rdy = r;
        b12.clr = c; b9.clr = c;
        @(posedge clk);
        model(v, d, r, c, rs);
        #1;
        chk("sum12", int'(b12.sum), m_sum[0]);
        chk("sum9", int'(b9.sum), m_sum[1]);
        chk("sum_vld12", int'(b12.sum_vld), m_sv);
        chk("sum_vld9", int'(b9.sum_vld), m_sv);
        chk("cnt12", int'(b12.cnt), frame_q.size());
        chk("cnt9", int'(b9.cnt), frame_q.size());
        chk("ovf12", int'(b12.ovf), m_ovf[0]);
        chk("ovf9", int'(b9.ovf), m_ovf[1]);
        chk("drop12", int'(b12.drop), m_drop);
        chk("drop9", int'(b9.drop), m_drop);
    endtask

    task automatic idle(input bit r);
        step(1'b0, 0, r, 1'b0, 1'b1);
    endtask

    task automatic prod(input int d, input bit r);
        step(1'b1, d, r, 1'b0, 1'b1);
    endtask

    int seq_a[4] = '{10, 20, 30, 40};

    initial begin
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("rst_sum", int'(b12.sum), 0);
        chk("rst_vld", int'(b12.sum_vld), 0);

        // single frame, consumer always ready
        foreach (seq_a[i]) prod(seq_a[i], 1'b1);
        chk("t1_sum", int'(b12.sum), 100);
        chk("t1_vld", int'(b12.sum_vld), 1);
        idle(1'b1);
        chk("t1_vld_fall", int'(b12.sum_vld), 0);

        // 225 x4 with gaps; narrow instance wraps and sets ovf
        for (int i = 0; i < LEN; i++) begin
            repeat ($urandom_range(0, 3)) idle(1'b1);
            prod(225, 1'b1);
        end
        chk("t2_sum12", int'(b12.sum), 900);
        chk("t2_sum9", int'(b9.sum), 388);
        chk("t2_ovf9", int'(b9.ovf), 1);
        chk("t2_ovf12", int'(b12.ovf), 0);
        for (int i = 0; i < 2 * LEN; i++) prod(225, 1'b1);
        chk("t2_ovf9_sticky", int'(b9.ovf), 1);
        idle(1'b1);
        step(1'b0, 0, 1'b1, 1'b1, 1'b1);
        chk("t2_ovf9_clr", int'(b9.ovf), 0);

        // back-pressure and drop
        for (int i = 1; i <= 4; i++) prod(i, 1'b0);
        chk("t3_sum", int'(b12.sum), 10);
        for (int i = 0; i < 4; i++) prod(5, 1'b0);
        chk("t3_drop", int'(b12.drop), 1);
        chk("t3_hold", int'(b12.sum), 10);
        idle(1'b0);
        chk("t3_drop_fall", int'(b12.drop), 0);
        idle(1'b1);
        chk("t3_vld_fall", int'(b12.sum_vld), 0);

        // accept and reload on the same edge
        for (int i = 1; i <= 4; i++) prod(i, 1'b0);
        for (int i = 0; i < 3; i++) prod(2, 1'b0);
        prod(2, 1'b1);
        chk("t4_sum", int'(b12.sum), 8);
        chk("t4_vld", int'(b12.sum_vld), 1);
        chk("t4_drop", int'(b12.drop), 0);
        idle(1'b1);

        // clr mid-frame, then clr while result is pending
        prod(50, 1'b1);
        prod(50, 1'b1);
        step(1'b1, 99, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) prod(1, 1'b0);
        chk("t5_sum", int'(b12.sum), 4);
        prod(7, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1, 1'b1);
        chk("t5_clr_keep_vld", int'(b12.sum_vld), 1);
        chk("t5_clr_keep_sum", int'(b12.sum), 4);
        idle(1'b1);

        // reset mid-frame
        prod(200, 1'b1);
        prod(200, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("t6_cnt", int'(b12.cnt), 0);
        for (int i = 0; i < 4; i++) prod(3, 1'b1);
        chk("t6_sum", int'(b12.sum), 12);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 3) == 0) ? 225 : int'($urandom_range(0, 255)),
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_acc.md
# mult_acc

Accumulator stage that sits directly downstream of the 4x4 ROM-based multiplier. It consumes the 8-bit product stream and its valid strobe, and sums every LEN consecutive valid products into one dot-product result. The result is presented in a single-entry output register with a valid/ready handshake. Frame count and overflow status are exposed for the consuming logic.

## Interface
- LEN, 8, products per frame (>=2)
- ACC_W, 12, accumulator/result width (>=8); full precision needs ACC_W >= 8+clog2(LEN)
- CNT_W, 4, frame counter width; must satisfy 2**CNT_W > LEN-1
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- clr  in  1  synchronous frame abort: clears accumulator, counter, ovf
- dat_in  in  8  product from multiplier
- dat_vld  in  1  dat_in valid this cycle (multiplier rdy)
- sum  out  ACC_W  frame result
- sum_vld  out  1  sum holds an unread result
- sum_rdy  in  1  consumer accepts sum when sum_vld=1
- cnt  out  CNT_W  products accepted in current frame
- ovf  out  1  sticky: an accumulate carried out of ACC_W
- drop  out  1  one-cycle pulse: completed frame discarded because output register full

## Operation
- Priority per cycle: rst_n low > clr > dat_vld.
- Reset (rst_n=0 at edge): acc=0, cnt=0, sum=0, sum_vld=0, ovf=0, drop=0.
- Accumulator FSM, two states:
  - IDLE (cnt=0): dat_vld=1 -> acc=dat_in zero-extended, cnt=1, go RUN.
  - RUN: dat_vld=1 and cnt<LEN-1 -> acc=acc+dat_in, cnt=cnt+1.
  - RUN, dat_vld=1 and cnt=LEN-1 (last product) -> final=acc+dat_in; acc=0, cnt=0, go IDLE; final offered to output register.
  - dat_vld=0: hold acc and cnt; gaps of any length allowed.
  - clr=1 in either state: acc=0, cnt=0, ovf=0, go IDLE; the dat_in of that cycle is ignored. Output register, sum_vld, and drop are unaffected.
- Arithmetic: unsigned, dat_in zero-extended to ACC_W; the result wraps modulo 2**ACC_W. A carry out of bit ACC_W-1 on any add sets ovf; ovf stays set until clr or reset.
- Output register, states EMPTY (sum_vld=0) and FULL (sum_vld=1):
  - Handshake completes when sum_vld=1 and sum_rdy=1.
  - When final is offered:
    - Register EMPTY, or FULL with the handshake completing the same cycle: sum=final, sum_vld=1.
    - Register FULL and sum_rdy=0: final is discarded, drop=1 for that cycle, and sum/sum_vld are unchanged. The accumulator restarts regardless.
  - Handshake with no final offered -> sum_vld=0; sum keeps its last value.
- sum, sum_vld, cnt, ovf, and drop are all registered outputs. No combinational path from inputs to outputs.

## Timing
- Latency: sum_vld rises on the edge that accepts the LEN-th product. Data is visible the cycle after the last dat_vld.
- Full throughput: one product per cycle. Back-to-back frames need no idle cycle.
- sum_rdy is sampled only while sum_vld=1. sum is stable while sum_vld=1 and sum_rdy=0.
- drop asserts one cycle after the discarded final product and lasts exactly one cycle.
- cnt reflects products accepted up to the previous edge. It reads 0 in the cycle after a frame completes.
- ovf updates on the same edge as the offending add.

## Test plan
- LEN=4, ACC_W=12, sum_rdy=1; dat_vld high for 4 cycles with 10,20,30,40 -> sum=100 and sum_vld=1 exactly one cycle after 40. Then sum_vld=0 next cycle, cnt=0, ovf=0.
- Same config; products 225 x4 with random dat_vld gaps of 0-3 cycles -> sum=900, ovf=0. Two back-to-back frames without gaps -> sum 900 then 900, two single-cycle sum_vld pulses.
- Back-pressure: sum_rdy=0, frame 1,2,3,4 -> sum=10 held. Second frame 5,5,5,5 completes -> drop pulse 1 cycle, sum stays 10. Raise sum_rdy -> sum_vld drops next cycle.
- Simultaneous: sum FULL=10, sum_rdy=1 on the cycle the next frame (2,2,2,2) ends -> sum=8, sum_vld stays 1, drop=0.
- clr mid-frame: accept 50,50, assert clr with dat_in=99, then 1,1,1,1 -> sum=4. clr during FULL output leaves sum/sum_vld intact.
- ACC_W=9, LEN=4, 225 x4 -> sum=388 (900 mod 512), ovf=1 and sticky into the next frame until clr. rst_n low mid-frame -> all outputs 0 on the next cycle, and the next frame sums from zero.
